// File: rtl/elevator_ctrl_n_if.sv
// Request/status bundle between the system top and the elevator controller.
// The master side presses buttons, supplies the tick strobe and occupancy
// pulses; the slave side (the controller) reports car position and status.
interface elevator_ctrl_n_if #(
    parameter int FLOORS = 3,
    parameter int CAP    = 5
);
    localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int CW = $clog2(CAP + 2);

    logic              tick;
    logic [FLOORS-1:0] call_ext;
    logic [FLOORS-1:0] call_int;
    logic              up;
    logic              down;
    logic [FW-1:0]     floor;
    logic [1:0]        engine;
    logic              door_open;
    logic              alarm;
    logic [CW-1:0]     people;
    logic [FLOORS-1:0] pending;

    modport master (
        output tick, call_ext, call_int, up, down,
        input  floor, engine, door_open, alarm, people, pending
    );

    modport slave (
        input  tick, call_ext, call_int, up, down,
        output floor, engine, door_open, alarm, people, pending
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// Single-car SCAN elevator controller for FLOORS floors.
// Latches hall and cabin calls, keeps travelling in the current direction
// while calls remain ahead, then reverses. Door dwell and floor-to-floor
// travel are timed in ticks; an occupancy counter with an overload alarm
// keeps the door open while the car is overloaded.
module elevator_ctrl_n #(
    parameter int FLOORS       = 3,
    parameter int CAP          = 5,
    parameter int DOOR_TICKS   = 3,
    parameter int TRAVEL_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset,
    elevator_ctrl_n_if.slave  bus
);
    localparam int FW  = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int CW  = $clog2(CAP + 2);
    localparam int DTW = $clog2(DOOR_TICKS + 1);
    localparam int TTW = $clog2(TRAVEL_TICKS + 1);

    localparam logic [FW-1:0]  TOP_FLOOR   = FW'(FLOORS - 1);
    localparam logic [CW-1:0]  PEOPLE_MAX  = '1;
    localparam logic [CW-1:0]  PEOPLE_CAP  = CW'(CAP);
    localparam logic [DTW-1:0] DOOR_LOAD   = DTW'(DOOR_TICKS);
    localparam logic [TTW-1:0] TRAVEL_LOAD = TTW'(TRAVEL_TICKS);

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_DOOR_OPEN
    } state_t;

    state_t            state_reg;
    logic              dir_reg;            // 0 = up, 1 = down
    logic [FW-1:0]     floor_reg;
    logic [1:0]        engine_reg;
    logic              door_open_reg;
    logic [DTW-1:0]    door_timer_reg;
    logic [TTW-1:0]    travel_timer_reg;
    logic [FLOORS-1:0] pending_reg;
    logic [CW-1:0]     people_reg;
    logic              alarm_reg;

    logic [FLOORS-1:0] call_mask;
    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] cur_onehot;
    logic [FLOORS-1:0] next_onehot;
    logic [FLOORS-1:0] pending_next;
    logic [FW-1:0]     floor_next;
    logic              ahead_up;
    logic              ahead_down;
    logic              ahead_fwd;
    logic              ahead_rev;
    logic              next_at_end;
    logic              repress;

    // Per-floor position masks relative to the current and the next floor.
    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_mask
            assign above_mask[gi]  = (int'(floor_reg) < gi);
            assign below_mask[gi]  = (int'(floor_reg) > gi);
            assign cur_onehot[gi]  = (int'(floor_reg) == gi);
            assign next_onehot[gi] = (int'(floor_next) == gi);
        end
    endgenerate

    assign call_mask  = bus.call_ext | bus.call_int;
    assign ahead_up   = |(pending_reg & above_mask);
    assign ahead_down = |(pending_reg & below_mask);
    assign ahead_fwd  = dir_reg ? ahead_down : ahead_up;
    assign ahead_rev  = dir_reg ? ahead_up   : ahead_down;

    // A press at the floor whose door is already open is served on the spot:
    // it never latches and instead restarts the dwell.
    assign repress = (state_reg == ST_DOOR_OPEN) && (|(call_mask & cur_onehot));

    // Next floor in the travel direction, clamped to the shaft.
    always_comb begin
        floor_next = floor_reg;
        if (!dir_reg && (floor_reg != TOP_FLOOR)) begin
            floor_next = floor_reg + FW'(1);
        end else if (dir_reg && (floor_reg != '0)) begin
            floor_next = floor_reg - FW'(1);
        end
    end

    assign next_at_end = (floor_next == '0) || (floor_next == TOP_FLOOR);

    // Call latch with the open-door floor masked out.
    always_comb begin
        pending_next = pending_reg | call_mask;
        if (state_reg == ST_DOOR_OPEN) begin
            pending_next = pending_next & ~cur_onehot;
        end
    end

    // Car FSM: call latch, direction, position, engine, door and both timers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            dir_reg          <= 1'b0;
            floor_reg        <= '0;
            engine_reg       <= ENG_STOP;
            door_open_reg    <= 1'b0;
            door_timer_reg   <= '0;
            travel_timer_reg <= '0;
            pending_reg      <= '0;
        end else begin
            pending_reg <= pending_next;
            if (repress) begin
                door_timer_reg <= DOOR_LOAD;
            end
            if (bus.tick) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (pending_reg[floor_reg]) begin
                            state_reg      <= ST_DOOR_OPEN;
                            door_open_reg  <= 1'b1;
                            door_timer_reg <= DOOR_LOAD;
                            pending_reg    <= pending_next & ~cur_onehot;
                        end else if (ahead_fwd) begin
                            state_reg        <= ST_MOVING;
                            engine_reg       <= dir_reg ? ENG_DOWN : ENG_UP;
                            travel_timer_reg <= TRAVEL_LOAD;
                        end else if (ahead_rev) begin
                            state_reg        <= ST_MOVING;
                            dir_reg          <= ~dir_reg;
                            engine_reg       <= dir_reg ? ENG_UP : ENG_DOWN;
                            travel_timer_reg <= TRAVEL_LOAD;
                        end
                    end
                    ST_MOVING: begin
                        if (travel_timer_reg <= TTW'(1)) begin
                            floor_reg <= floor_next;
                            if (pending_reg[floor_next]) begin
                                state_reg        <= ST_DOOR_OPEN;
                                engine_reg       <= ENG_STOP;
                                door_open_reg    <= 1'b1;
                                door_timer_reg   <= DOOR_LOAD;
                                travel_timer_reg <= '0;
                                pending_reg      <= pending_next & ~next_onehot;
                            end else if (next_at_end) begin
                                // Unreachable while calls only clear on arrival;
                                // park safely rather than drive into the end stop.
                                state_reg        <= ST_IDLE;
                                engine_reg       <= ENG_STOP;
                                travel_timer_reg <= '0;
                            end else begin
                                travel_timer_reg <= TRAVEL_LOAD;
                            end
                        end else begin
                            travel_timer_reg <= travel_timer_reg - TTW'(1);
                        end
                    end
                    ST_DOOR_OPEN: begin
                        if (!repress) begin
                            if (door_timer_reg <= DTW'(1)) begin
                                if (alarm_reg) begin
                                    door_timer_reg <= DOOR_LOAD;
                                end else begin
                                    state_reg      <= ST_IDLE;
                                    door_open_reg  <= 1'b0;
                                    door_timer_reg <= '0;
                                end
                            end else begin
                                door_timer_reg <= door_timer_reg - DTW'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        engine_reg    <= ENG_STOP;
                        door_open_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Occupancy counter, active only while the door is open; alarm lags by one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            people_reg <= '0;
            alarm_reg  <= 1'b0;
        end else begin
            alarm_reg <= (people_reg > PEOPLE_CAP);
            if (door_open_reg) begin
                if (bus.up && !bus.down && (people_reg != PEOPLE_MAX)) begin
                    people_reg <= people_reg + CW'(1);
                end else if (bus.down && !bus.up && (people_reg != '0)) begin
                    people_reg <= people_reg - CW'(1);
                end
            end
        end
    end

    assign bus.floor     = floor_reg;
    assign bus.engine    = engine_reg;
    assign bus.door_open = door_open_reg;
    assign bus.alarm     = alarm_reg;
    assign bus.people    = people_reg;
    assign bus.pending   = pending_reg;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n with FLOORS=4, CAP=5, DOOR_TICKS=3,
// TRAVEL_TICKS=2. Inputs change on the falling edge; outputs are read there.
module tb_elevator_ctrl_n;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    elevator_ctrl_n_if #(.FLOORS(4), .CAP(5)) bus ();

    elevator_ctrl_n #(
        .FLOORS(4), .CAP(5), .DOOR_TICKS(3), .TRAVEL_TICKS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two clocks, release on a falling edge.
    task automatic do_reset();
        reset        = 1'b0;
        bus.tick     = 1'b0;
        bus.call_ext = '0;
        bus.call_int = '0;
        bus.up       = 1'b0;
        bus.down     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // n consecutive tick edges.
    task automatic do_ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    task automatic press_int(input int f);
        bus.call_int[f] = 1'b1;
        @(negedge clk);
        bus.call_int = '0;
    endtask

    task automatic press_ext(input logic [3:0] m);
        bus.call_ext = m;
        @(negedge clk);
        bus.call_ext = '0;
    endtask

    task automatic pulse_people(input logic u, input logic d);
        bus.up   = u;
        bus.down = d;
        @(negedge clk);
        bus.up   = 1'b0;
        bus.down = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.floor !== 2'd0) begin tests_failed++; $display("FAIL reset_floor: got %0d expected 0", bus.floor); end
        tests_run++;
        if (bus.engine !== 2'b00 || bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL reset_engine_door: engine=%b door=%b expected 00/0", bus.engine, bus.door_open); end
        tests_run++;
        if (bus.alarm !== 1'b0 || bus.people !== 3'd0 || bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_status: alarm=%b people=%0d pending=%b expected 0/0/0000", bus.alarm, bus.people, bus.pending); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_travel();
        do_reset();
        press_int(3);
        tests_run++;
        if (bus.pending !== 4'b1000) begin tests_failed++; $display("FAIL travel_latch: pending=%b expected 1000", bus.pending); end
        do_ticks(1);
        tests_run++;
        if (bus.engine !== 2'b01 || bus.floor !== 2'd0) begin tests_failed++; $display("FAIL travel_start: engine=%b floor=%0d expected 01/0", bus.engine, bus.floor); end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd1) begin tests_failed++; $display("FAIL travel_f1: floor=%0d expected 1", bus.floor); end
        do_ticks(1);
        tests_run++;
        if (bus.floor !== 2'd1) begin tests_failed++; $display("FAIL travel_hold: floor=%0d expected 1", bus.floor); end
        do_ticks(1);
        tests_run++;
        if (bus.floor !== 2'd2) begin tests_failed++; $display("FAIL travel_f2: floor=%0d expected 2", bus.floor); end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd3 || bus.engine !== 2'b00 || bus.door_open !== 1'b1 || bus.pending !== 4'b0000) begin
            tests_failed++;
            $display("FAIL travel_arrive: floor=%0d engine=%b door=%b pending=%b expected 3/00/1/0000", bus.floor, bus.engine, bus.door_open, bus.pending);
        end
        do_ticks(2);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL travel_dwell: door=%b expected 1", bus.door_open); end
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL travel_close: door=%b expected 0", bus.door_open); end
        $display("[TB] test_travel done");
    endtask

    task automatic test_scan();
        do_reset();
        press_int(3);
        do_ticks(3);
        tests_run++;
        if (bus.floor !== 2'd1 || bus.engine !== 2'b01) begin tests_failed++; $display("FAIL scan_setup: floor=%0d engine=%b expected 1/01", bus.floor, bus.engine); end
        press_ext(4'b0101);
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd2 || bus.door_open !== 1'b1 || bus.pending !== 4'b1001) begin
            tests_failed++;
            $display("FAIL scan_stop2: floor=%0d door=%b pending=%b expected 2/1/1001", bus.floor, bus.door_open, bus.pending);
        end
        do_ticks(4);
        tests_run++;
        if (bus.engine !== 2'b01) begin tests_failed++; $display("FAIL scan_resume_up: engine=%b expected 01", bus.engine); end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd3 || bus.door_open !== 1'b1 || bus.pending !== 4'b0001) begin
            tests_failed++;
            $display("FAIL scan_stop3: floor=%0d door=%b pending=%b expected 3/1/0001", bus.floor, bus.door_open, bus.pending);
        end
        do_ticks(4);
        tests_run++;
        if (bus.engine !== 2'b10) begin tests_failed++; $display("FAIL scan_reverse: engine=%b expected 10", bus.engine); end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd2 || bus.engine !== 2'b10 || bus.door_open !== 1'b0) begin
            tests_failed++;
            $display("FAIL scan_pass2: floor=%0d engine=%b door=%b expected 2/10/0", bus.floor, bus.engine, bus.door_open);
        end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd1 || bus.engine !== 2'b10) begin tests_failed++; $display("FAIL scan_pass1: floor=%0d engine=%b expected 1/10", bus.floor, bus.engine); end
        do_ticks(2);
        tests_run++;
        if (bus.floor !== 2'd0 || bus.door_open !== 1'b1 || bus.engine !== 2'b00 || bus.pending !== 4'b0000) begin
            tests_failed++;
            $display("FAIL scan_stop0: floor=%0d door=%b engine=%b pending=%b expected 0/1/00/0000", bus.floor, bus.door_open, bus.engine, bus.pending);
        end
        $display("[TB] test_scan done");
    endtask

    task automatic test_overload();
        do_reset();
        press_int(0);
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL ovl_open: door=%b expected 1", bus.door_open); end
        repeat (6) pulse_people(1'b1, 1'b0);
        tests_run++;
        if (bus.people !== 3'd6 || bus.alarm !== 1'b0) begin tests_failed++; $display("FAIL ovl_count: people=%0d alarm=%b expected 6/0", bus.people, bus.alarm); end
        @(negedge clk);
        tests_run++;
        if (bus.alarm !== 1'b1) begin tests_failed++; $display("FAIL ovl_alarm: alarm=%b expected 1", bus.alarm); end
        do_ticks(6);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL ovl_hold: door=%b expected 1", bus.door_open); end
        pulse_people(1'b0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (bus.people !== 3'd5 || bus.alarm !== 1'b0) begin tests_failed++; $display("FAIL ovl_clear: people=%0d alarm=%b expected 5/0", bus.people, bus.alarm); end
        do_ticks(2);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL ovl_dwell: door=%b expected 1", bus.door_open); end
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL ovl_close: door=%b expected 0", bus.door_open); end
        $display("[TB] test_overload done");
    endtask

    task automatic test_counting();
        do_reset();
        press_int(0);
        do_ticks(1);
        pulse_people(1'b1, 1'b0);
        tests_run++;
        if (bus.people !== 3'd1) begin tests_failed++; $display("FAIL cnt_up: people=%0d expected 1", bus.people); end
        pulse_people(1'b1, 1'b1);
        tests_run++;
        if (bus.people !== 3'd1) begin tests_failed++; $display("FAIL cnt_both: people=%0d expected 1", bus.people); end
        pulse_people(1'b0, 1'b1);
        pulse_people(1'b0, 1'b1);
        tests_run++;
        if (bus.people !== 3'd0) begin tests_failed++; $display("FAIL cnt_floor0: people=%0d expected 0", bus.people); end
        do_ticks(3);
        tests_run++;
        if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL cnt_closed: door=%b expected 0", bus.door_open); end
        pulse_people(1'b1, 1'b0);
        pulse_people(1'b1, 1'b0);
        tests_run++;
        if (bus.people !== 3'd0) begin tests_failed++; $display("FAIL cnt_ignored: people=%0d expected 0", bus.people); end
        $display("[TB] test_counting done");
    endtask

    task automatic test_repress();
        do_reset();
        press_int(0);
        do_ticks(1);
        do_ticks(2);
        press_ext(4'b0001);
        tests_run++;
        if (bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL repress_pending: pending=%b expected 0000", bus.pending); end
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL repress_extend: door=%b expected 1", bus.door_open); end
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL repress_extend2: door=%b expected 1", bus.door_open); end
        do_ticks(1);
        tests_run++;
        if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL repress_close: door=%b expected 0", bus.door_open); end
        $display("[TB] test_repress done");
    endtask

    task automatic test_async_reset();
        do_reset();
        press_int(3);
        do_ticks(5);
        press_ext(4'b0010);
        tests_run++;
        if (bus.floor !== 2'd2 || bus.engine !== 2'b01 || bus.pending !== 4'b1010) begin
            tests_failed++;
            $display("FAIL arst_setup: floor=%0d engine=%b pending=%b expected 2/01/1010", bus.floor, bus.engine, bus.pending);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (bus.floor !== 2'd0 || bus.engine !== 2'b00 || bus.door_open !== 1'b0 || bus.pending !== 4'b0000 || bus.alarm !== 1'b0 || bus.people !== 3'd0) begin
            tests_failed++;
            $display("FAIL arst_immediate: floor=%0d engine=%b door=%b pending=%b expected 0/00/0/0000", bus.floor, bus.engine, bus.door_open, bus.pending);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_ticks(3);
        tests_run++;
        if (bus.floor !== 2'd0 || bus.engine !== 2'b00 || bus.door_open !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_idle: floor=%0d engine=%b door=%b expected 0/00/0", bus.floor, bus.engine, bus.door_open);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus.tick     = 1'b0;
        bus.call_ext = '0;
        bus.call_int = '0;
        bus.up       = 1'b0;
        bus.down     = 1'b0;
        @(negedge clk);
        test_reset();
        test_travel();
        test_scan();
        test_overload();
        test_counting();
        test_repress();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
